frame_writer: RTL and testbench

- Downstream sink for the zoom_horizontal output stream.
- Collects an OUT_WIDTH x OUT_HEIGHT zoomed frame and writes it pixel-by-pixel into a double-buffered (ping-pong) frame memory through an external write port.
- Hands completed frames to the display side with a bank/valid/ack protocol.
- Back-pressures the zoom pipeline when both banks are occupied.

---
 rtl/frame_writer.sv | 125 ++++++++++++
 tb/tb_frame_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// frame_writer: sink for the zoomed pixel stream. Writes each OUT_WIDTH x
// OUT_HEIGHT frame row-major into one half of a ping-pong frame memory and
// hands completed banks to the display side with a bank/valid/ack handshake.
module frame_writer #(
    parameter int OUT_WIDTH  = 8,
    parameter int OUT_HEIGHT = 8,
    parameter int DATA_W     = 8,
    parameter int PIX_W      = $clog2(OUT_WIDTH*OUT_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid_in,
    output logic              pixel_ready_out,
    input  logic              frame_restart,
    output logic              mem_we,
    output logic [PIX_W:0]    mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              display_bank,
    output logic              display_valid,
    input  logic              display_ack,
    output logic              frame_done,
    output logic [7:0]        frame_count
);

    localparam int               NPIX     = OUT_WIDTH * OUT_HEIGHT;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);

    typedef enum logic {
        S_WRITE     = 1'b0,
        S_WAIT_BANK = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_write_bank;
    logic [PIX_W-1:0]  r_pix_cnt;
    logic              r_mem_we;
    logic [PIX_W:0]    r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_display_bank;
    logic              r_display_valid;
    logic              r_frame_done;
    logic [7:0]        r_frame_count;

    logic w_state_ready;
    logic w_accept;
    logic w_take;
    logic w_last;

    // Ready depends only on the state register; held low during reset.
    assign w_state_ready   = (r_state == S_WRITE);
    assign pixel_ready_out = w_state_ready && !rst;
    assign w_accept        = pixel_valid_in && w_state_ready;
    assign w_take          = w_accept && !frame_restart;
    assign w_last          = (r_pix_cnt == LAST_PIX);

    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign display_bank  = r_display_bank;
    assign display_valid = r_display_valid;
    assign frame_done    = r_frame_done;
    assign frame_count   = r_frame_count;

    // Write port, pixel counter, bank ownership FSM and frame bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_WRITE;
            r_write_bank    <= 1'b0;
            r_pix_cnt       <= '0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_display_bank  <= 1'b0;
            r_display_valid <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_count   <= 8'd0;
        end else begin
            r_mem_we     <= w_take;
            r_frame_done <= 1'b0;
            if (w_take) begin
                r_mem_addr  <= {r_write_bank, r_pix_cnt};
                r_mem_wdata <= pixel_in;
            end
            case (r_state)
                S_WRITE: begin
                    // A release without a completing frame just frees the bank;
                    // a completion below overrides this.
                    if (display_ack && r_display_valid) begin
                        r_display_valid <= 1'b0;
                    end
                    if (frame_restart) begin
                        r_pix_cnt <= '0;
                    end else if (w_accept) begin
                        if (w_last) begin
                            r_pix_cnt     <= '0;
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + 8'd1;
                            if (!r_display_valid || display_ack) begin
                                r_display_bank  <= r_write_bank;
                                r_display_valid <= 1'b1;
                                r_write_bank    <= ~r_write_bank;
                            end else begin
                                r_state <= S_WAIT_BANK;
                            end
                        end else begin
                            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                        end
                    end
                end
                S_WAIT_BANK: begin
                    // Both banks full: hand over the finished one once the
                    // display releases the other.
                    if (display_ack) begin
                        r_display_bank <= r_write_bank;
                        r_write_bank   <= ~r_write_bank;
                        r_state        <= S_WRITE;
                    end
                end
                default: r_state <= S_WRITE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed and randomized bench for frame_writer with a
// frame-level reference model (4x2 frames, 8 pixels per bank).
module tb_frame_writer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int DW = 8;
    localparam int PW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pixel_in;
    logic          pixel_valid_in;
    logic          pixel_ready_out;
    logic          frame_restart;
    logic          mem_we;
    logic [PW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          display_bank;
    logic          display_valid;
    logic          display_ack;
    logic          frame_done;
    logic [7:0]    frame_count;

    frame_writer #(
        .OUT_WIDTH (W),
        .OUT_HEIGHT(H),
        .DATA_W    (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_in       (pixel_in),
        .pixel_valid_in (pixel_valid_in),
        .pixel_ready_out(pixel_ready_out),
        .frame_restart  (frame_restart),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .display_bank   (display_bank),
        .display_valid  (display_valid),
        .display_ack    (display_ack),
        .frame_done     (frame_done),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which bank is being filled, how far into it, which
    // bank the display owns, and whether the writer is stalled on a full pair.
    int m_bank, m_cnt, m_dbank, m_dv, m_wait, m_count, m_frames;
    int m_we, m_done, m_addr, m_wdata;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bank = 0; m_cnt = 0; m_dbank = 0; m_dv = 0; m_wait = 0;
        m_count = 0; m_frames = 0; m_we = 0; m_done = 0; m_addr = 0; m_wdata = 0;
    endtask

    task automatic compare();
        chk("ready", int'(pixel_ready_out), (m_wait == 0) ? 1 : 0);
        chk("mem_we", int'(mem_we), m_we);
        chk("frame_done", int'(frame_done), m_done);
        chk("frame_count", int'(frame_count), m_count);
        chk("display_bank", int'(display_bank), m_dbank);
        chk("display_valid", int'(display_valid), m_dv);
        if (m_we != 0) begin
            chk("mem_addr", int'(mem_addr), m_addr);
            chk("mem_wdata", int'(mem_wdata), m_wdata);
        end
        if (mem_we && !frame_done && display_valid)
            chk("bank_excl", int'(mem_addr[PW]), int'(!display_bank));
    endtask

    // Apply one cycle of inputs, advance the model, then check outputs.
    task automatic step(input logic v, input logic [7:0] px, input logic rs, input logic ack);
        pixel_valid_in = v;
        pixel_in       = px;
        frame_restart  = rs;
        display_ack    = ack;
        m_we   = 0;
        m_done = 0;
        if (m_wait == 0) begin
            if (rs) begin
                m_cnt = 0;
                if (ack) m_dv = 0;
            end else if (v) begin
                m_we    = 1;
                m_addr  = m_bank * N + m_cnt;
                m_wdata = int'(px);
                if (m_cnt == N - 1) begin
                    m_cnt   = 0;
                    m_done  = 1;
                    m_count = (m_count + 1) % 256;
                    m_frames++;
                    if (m_dv == 0 || ack) begin
                        m_dbank = m_bank;
                        m_dv    = 1;
                        m_bank  = 1 - m_bank;
                    end else begin
                        m_wait = 1;
                    end
                end else begin
                    m_cnt++;
                    if (ack) m_dv = 0;
                end
            end else if (ack) begin
                m_dv = 0;
            end
        end else if (ack) begin
            m_dbank = m_bank;
            m_bank  = 1 - m_bank;
            m_wait  = 0;
        end
        @(negedge clk);
        compare();
    endtask

    int guard;
    int saw_wrap;

    initial begin
        rst = 1'b1; pixel_in = '0; pixel_valid_in = 1'b0;
        frame_restart = 1'b0; display_ack = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", int'(pixel_ready_out), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        chk("rst_dvalid", int'(display_valid), 0);
        chk("rst_count", int'(frame_count), 0);
        rst = 1'b0;
        #1;
        compare();

        // Frame 1: back-to-back pixels into bank 0.
        for (int i = 0; i < N; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            chk("f1_we", int'(mem_we), 1);
            chk("f1_addr", int'(mem_addr), i);
            chk("f1_data", int'(mem_wdata), 16 + i);
        end
        chk("f1_done", int'(frame_done), 1);
        chk("f1_count", int'(frame_count), 1);
        chk("f1_dvalid", int'(display_valid), 1);
        chk("f1_dbank", int'(display_bank), 0);
        chk("f1_ready", int'(pixel_ready_out), 1);

        // Frame 2 into bank 1 without a release: writer must stall.
        for (int i = 0; i < N; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
            chk("f2_addr", int'(mem_addr), 8 + i);
        end
        chk("f2_done", int'(frame_done), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h55, 1'b0, 1'b0);
            chk("wait_ready", int'(pixel_ready_out), 0);
            chk("wait_we", int'(mem_we), 0);
        end
        step(1'b1, 8'h55, 1'b0, 1'b1);
        chk("ack_dbank", int'(display_bank), 1);
        chk("ack_ready", int'(pixel_ready_out), 1);
        chk("ack_we", int'(mem_we), 0);

        // Frame 3 into bank 0, release coincident with the last pixel.
        for (int i = 0; i < N; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b0, (i == N - 1) ? 1'b1 : 1'b0);
            chk("f3_addr", int'(mem_addr), i);
            chk("f3_ready", int'(pixel_ready_out), 1);
        end
        chk("f3_dbank", int'(display_bank), 0);
        chk("f3_dvalid", int'(display_valid), 1);
        chk("f3_count", int'(frame_count), 3);

        // Restart mid-frame: the coincident pixel is dropped.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("rs_we", int'(mem_we), 0);
        step(1'b1, 8'h4F, 1'b0, 1'b0);
        chk("rs_addr", int'(mem_addr), 8);
        chk("rs_data", int'(mem_wdata), 8'h4F);
        chk("rs_done", int'(frame_done), 0);

        // Asynchronous reset after 5 accepted pixels in the frame.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_we", int'(mem_we), 0);
        chk("arst_dvalid", int'(display_valid), 0);
        chk("arst_count", int'(frame_count), 0);
        chk("arst_ready", int'(pixel_ready_out), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare();
        step(1'b1, 8'h61, 1'b0, 1'b0);
        chk("arst_addr", int'(mem_addr), 0);

        // Randomized traffic until 300 frames complete since the reset.
        guard = 0;
        saw_wrap = 0;
        while (m_frames < 300 && guard < 60000) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
            if (frame_done && frame_count == 8'd0) saw_wrap = 1;
            guard++;
        end
        chk("rand_frames", m_frames, 300);
        chk("rand_wrap", saw_wrap, 1);
        chk("rand_count", int'(frame_count), 44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
